display_compositor: RTL and testbench

- Next-generation pixel compositor for the VGA path, clocked at 50 MHz and advanced by a pixel strobe.
- Centres an image of run-time geometry on screen and generates framebuffer read addresses incrementally, with no per-pixel multiply.
- Aligns RAM read latency and overlays a mouse cursor plus a mouse-dragged region-of-interest (ROI) rectangle.
- Sits between the VGA timing driver (next_x/next_y) and its color_in; ROI outputs feed the scaler/copier.

---
 rtl/display_pkg.sv | 39 +++
 rtl/roi_selector.sv | 134 +++++++++++++
 rtl/display_compositor.sv | 156 +++++++++++++++
 tb/tb_display_compositor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, defaults and small coordinate helpers for the VGA compositor path.
package display_pkg;

    localparam int         H_ACTIVE_DEF  = 640;
    localparam int         V_ACTIVE_DEF  = 480;
    localparam logic [7:0] CUR_COLOR_DEF = 8'hFF;
    localparam logic [7:0] ROI_COLOR_DEF = 8'hE0;
    localparam logic [7:0] BG_COLOR_DEF  = 8'h00;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAG = 2'd1,
        DONE = 2'd2
    } roi_state_t;

    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        coord_min = (a < b) ? a : b;
    endfunction

    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        coord_max = (a > b) ? a : b;
    endfunction

    // Screen coordinate to image-local, clamped into [0, len-1]
    function automatic coord_t clamp_local(input coord_t pos, input coord_t off, input coord_t len);
        coord_t diff;
        diff = pos - off;
        if (pos < off) begin
            clamp_local = 10'd0;
        end else if (diff >= len) begin
            clamp_local = len - 10'd1;
        end else begin
            clamp_local = diff;
        end
    endfunction

endpackage

// File: rtl/roi_selector.sv
// Mouse-dragged region-of-interest: button synchroniser, edge detect, cursor clamp
// into image-local space, the IDLE/DRAG/DONE machine and corner sorting.
module roi_selector
    import display_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_left_btn,
    input  coord_t     i_cursor_x,
    input  coord_t     i_cursor_y,
    input  coord_t     i_x_off,
    input  coord_t     i_y_off,
    input  coord_t     i_img_w,
    input  coord_t     i_img_h,
    output coord_t     o_roi_x0,
    output coord_t     o_roi_y0,
    output coord_t     o_roi_x1,
    output coord_t     o_roi_y1,
    output logic       o_roi_valid,
    output logic       o_roi_busy,
    output roi_state_t o_state
);

    logic [1:0] r_btn_sync;
    logic       r_btn_d;
    logic       w_rise;
    logic       w_fall;
    coord_t     w_cur_x;
    coord_t     w_cur_y;
    roi_state_t r_state;
    roi_state_t w_state_nxt;
    coord_t     r_anchor_x, r_anchor_y, w_anchor_x_nxt, w_anchor_y_nxt;
    coord_t     r_x0, r_y0, r_x1, r_y1;
    coord_t     w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt;
    logic       r_busy, r_valid, w_busy_nxt, w_valid_nxt;

    // Two-flop synchroniser followed by one delay stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_sync <= 2'b00;
            r_btn_d    <= 1'b0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], i_left_btn};
            r_btn_d    <= r_btn_sync[1];
        end
    end

    assign w_rise  = r_btn_sync[1] & ~r_btn_d;
    assign w_fall  = ~r_btn_sync[1] & r_btn_d;
    assign w_cur_x = clamp_local(i_cursor_x, i_x_off, i_img_w);
    assign w_cur_y = clamp_local(i_cursor_y, i_y_off, i_img_h);

    // Next state, anchor and sorted corners
    always_comb begin
        w_state_nxt    = r_state;
        w_anchor_x_nxt = r_anchor_x;
        w_anchor_y_nxt = r_anchor_y;
        w_x0_nxt       = r_x0;
        w_y0_nxt       = r_y0;
        w_x1_nxt       = r_x1;
        w_y1_nxt       = r_y1;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = r_valid;
        case (r_state)
            IDLE, DONE: begin
                if (w_rise) begin
                    w_state_nxt    = DRAG;
                    w_anchor_x_nxt = w_cur_x;
                    w_anchor_y_nxt = w_cur_y;
                    w_x0_nxt       = w_cur_x;
                    w_y0_nxt       = w_cur_y;
                    w_x1_nxt       = w_cur_x;
                    w_y1_nxt       = w_cur_y;
                    w_busy_nxt     = 1'b1;
                    w_valid_nxt    = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            DRAG: begin
                w_x0_nxt = coord_min(r_anchor_x, w_cur_x);
                w_x1_nxt = coord_max(r_anchor_x, w_cur_x);
                w_y0_nxt = coord_min(r_anchor_y, w_cur_y);
                w_y1_nxt = coord_max(r_anchor_y, w_cur_y);
                if (w_fall) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = DRAG;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, anchor and corner registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_anchor_x <= 10'd0;
            r_anchor_y <= 10'd0;
            r_x0       <= 10'd0;
            r_y0       <= 10'd0;
            r_x1       <= 10'd0;
            r_y1       <= 10'd0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_anchor_x <= w_anchor_x_nxt;
            r_anchor_y <= w_anchor_y_nxt;
            r_x0       <= w_x0_nxt;
            r_y0       <= w_y0_nxt;
            r_x1       <= w_x1_nxt;
            r_y1       <= w_y1_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign o_roi_x0    = r_x0;
    assign o_roi_y0    = r_y0;
    assign o_roi_x1    = r_x1;
    assign o_roi_y1    = r_y1;
    assign o_roi_valid = r_valid;
    assign o_roi_busy  = r_busy;
    assign o_state     = r_state;

endmodule

// File: rtl/display_compositor.sv
// Pixel compositor: centred-image address generation, RAM latency alignment,
// and cursor / ROI outline overlay ahead of the VGA driver.
module display_compositor
    import display_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_DEF,
    parameter int          V_ACTIVE  = V_ACTIVE_DEF,
    parameter int          AW        = 19,
    parameter int          CW        = 8,
    parameter int          RD_LAT    = 1,
    parameter int          CUR_SIZE  = 5,
    parameter logic [CW-1:0] CUR_COLOR = CW'(CUR_COLOR_DEF),
    parameter logic [CW-1:0] ROI_COLOR = CW'(ROI_COLOR_DEF),
    parameter logic [CW-1:0] BG_COLOR  = CW'(BG_COLOR_DEF)
) (
    input  logic          clk_50MHz,
    input  logic          vga_reset,
    input  logic          pix_en,
    input  logic [9:0]    next_x,
    input  logic [9:0]    next_y,
    input  logic [9:0]    img_w,
    input  logic [9:0]    img_h,
    input  logic          display_enable,
    output logic [AW-1:0] fb_rdaddr,
    input  logic [CW-1:0] fb_q,
    input  logic [9:0]    cursor_x,
    input  logic [9:0]    cursor_y,
    input  logic          left_btn,
    output logic [CW-1:0] color_out,
    output logic [9:0]    roi_x0,
    output logic [9:0]    roi_y0,
    output logic [9:0]    roi_x1,
    output logic [9:0]    roi_y1,
    output logic          roi_valid,
    output logic          roi_busy
);

    localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
    localparam logic [10:0] CUR11   = 11'(CUR_SIZE);

    coord_t          r_img_w, r_img_h, r_x_off, r_y_off;
    coord_t          w_geo_w, w_geo_h, w_geo_xo, w_geo_yo;
    coord_t          w_new_xo, w_new_yo;
    logic            w_frame_start;
    logic [AW-1:0]   r_row_base, w_row_base_eff;
    logic [10:0]     w_x11, w_y11, w_xe11, w_ye11, w_cxe11, w_cye11;
    logic            w_in_img, w_row_end, w_cur_hit, w_roi_hit, w_on_vert, w_on_horz;
    coord_t          w_lx, w_ly;
    logic [RD_LAT:0] r_img_pipe, r_cur_pipe, r_roi_pipe;
    logic [CW-1:0]   w_color;
    roi_state_t      w_roi_state;

    assign w_frame_start = pix_en && (next_x == 10'd0) && (next_y == 10'd0);
    assign w_new_xo      = 10'((H_ACT11 - {1'b0, img_w}) >> 1);
    assign w_new_yo      = 10'((V_ACT11 - {1'b0, img_h}) >> 1);

    // The frame-start strobe already uses the geometry it is latching
    always_comb begin
        if (w_frame_start) begin
            w_geo_w        = img_w;
            w_geo_h        = img_h;
            w_geo_xo       = w_new_xo;
            w_geo_yo       = w_new_yo;
            w_row_base_eff = {AW{1'b0}};
        end else begin
            w_geo_w        = r_img_w;
            w_geo_h        = r_img_h;
            w_geo_xo       = r_x_off;
            w_geo_yo       = r_y_off;
            w_row_base_eff = r_row_base;
        end
    end

    assign w_x11     = {1'b0, next_x};
    assign w_y11     = {1'b0, next_y};
    assign w_xe11    = {1'b0, w_geo_xo} + {1'b0, w_geo_w};
    assign w_ye11    = {1'b0, w_geo_yo} + {1'b0, w_geo_h};
    assign w_in_img  = (w_x11 >= {1'b0, w_geo_xo}) && (w_x11 < w_xe11) &&
                       (w_y11 >= {1'b0, w_geo_yo}) && (w_y11 < w_ye11);
    assign w_row_end = w_in_img && (w_x11 == (w_xe11 - 11'd1));
    assign w_lx      = next_x - w_geo_xo;
    assign w_ly      = next_y - w_geo_yo;

    // Cursor square is clipped at the visible edge; 11-bit sums avoid wrap to column 0
    assign w_cxe11   = {1'b0, cursor_x} + CUR11;
    assign w_cye11   = {1'b0, cursor_y} + CUR11;
    assign w_cur_hit = (w_x11 < H_ACT11) && (w_y11 < V_ACT11) &&
                       (w_x11 >= {1'b0, cursor_x}) && (w_x11 < w_cxe11) &&
                       (w_y11 >= {1'b0, cursor_y}) && (w_y11 < w_cye11);

    assign w_on_vert = ((w_lx == roi_x0) || (w_lx == roi_x1)) && (w_ly >= roi_y0) && (w_ly <= roi_y1);
    assign w_on_horz = ((w_ly == roi_y0) || (w_ly == roi_y1)) && (w_lx >= roi_x0) && (w_lx <= roi_x1);
    assign w_roi_hit = ((w_roi_state == DRAG) || (w_roi_state == DONE)) && w_in_img &&
                       (w_on_vert || w_on_horz);

    // Overlay priority at the output of the latency-matched pipe
    always_comb begin
        if (r_cur_pipe[RD_LAT]) begin
            w_color = CUR_COLOR;
        end else if (r_roi_pipe[RD_LAT]) begin
            w_color = ROI_COLOR;
        end else if (r_img_pipe[RD_LAT]) begin
            w_color = fb_q;
        end else begin
            w_color = BG_COLOR;
        end
    end

    // Pixel-rate state: geometry, row base, read address, alignment pipe and colour
    always_ff @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) begin
            r_img_w    <= 10'(H_ACTIVE);
            r_img_h    <= 10'(V_ACTIVE);
            r_x_off    <= 10'd0;
            r_y_off    <= 10'd0;
            r_row_base <= {AW{1'b0}};
            fb_rdaddr  <= {AW{1'b0}};
            r_img_pipe <= {(RD_LAT+1){1'b0}};
            r_cur_pipe <= {(RD_LAT+1){1'b0}};
            r_roi_pipe <= {(RD_LAT+1){1'b0}};
            color_out  <= BG_COLOR;
        end else if (pix_en) begin
            r_img_w    <= w_geo_w;
            r_img_h    <= w_geo_h;
            r_x_off    <= w_geo_xo;
            r_y_off    <= w_geo_yo;
            r_row_base <= w_row_end ? (w_row_base_eff + AW'(w_geo_w)) : w_row_base_eff;
            fb_rdaddr  <= (w_in_img && display_enable) ? (w_row_base_eff + AW'(w_lx)) : {AW{1'b0}};
            r_img_pipe <= {r_img_pipe[RD_LAT-1:0], w_in_img && display_enable};
            r_cur_pipe <= {r_cur_pipe[RD_LAT-1:0], w_cur_hit};
            r_roi_pipe <= {r_roi_pipe[RD_LAT-1:0], w_roi_hit};
            color_out  <= w_color;
        end
    end

    roi_selector u_roi_selector (
        .i_clk       (clk_50MHz),
        .i_rst_n     (vga_reset),
        .i_left_btn  (left_btn),
        .i_cursor_x  (cursor_x),
        .i_cursor_y  (cursor_y),
        .i_x_off     (r_x_off),
        .i_y_off     (r_y_off),
        .i_img_w     (r_img_w),
        .i_img_h     (r_img_h),
        .o_roi_x0    (roi_x0),
        .o_roi_y0    (roi_y0),
        .o_roi_x1    (roi_x1),
        .o_roi_y1    (roi_y1),
        .o_roi_valid (roi_valid),
        .o_roi_busy  (roi_busy),
        .o_state     (w_roi_state)
    );

endmodule

// File: tb/tb_display_compositor.sv
// Self-checking bench for display_compositor: sparse raster scans against an
// arithmetic reference model, plus directed ROI drags and a mid-drag reset.
module tb_display_compositor;

    localparam int LAG = 2;

    logic        clk_50MHz = 1'b0;
    logic        vga_reset;
    logic        pix_en;
    logic [9:0]  next_x, next_y, img_w, img_h;
    logic        display_enable;
    logic [18:0] fb_rdaddr;
    logic [7:0]  fb_q;
    logic [9:0]  cursor_x, cursor_y;
    logic        left_btn;
    logic [7:0]  color_out;
    logic [9:0]  roi_x0, roi_y0, roi_x1, roi_y1;
    logic        roi_valid, roi_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int m_w, m_h, m_xo, m_yo;
    bit m_roi_on;
    int m_rx0, m_ry0, m_rx1, m_ry1;
    int exp_q[$];

    logic [18:0] ram_addr_q;

    display_compositor dut (
        .clk_50MHz      (clk_50MHz),
        .vga_reset      (vga_reset),
        .pix_en         (pix_en),
        .next_x         (next_x),
        .next_y         (next_y),
        .img_w          (img_w),
        .img_h          (img_h),
        .display_enable (display_enable),
        .fb_rdaddr      (fb_rdaddr),
        .fb_q           (fb_q),
        .cursor_x       (cursor_x),
        .cursor_y       (cursor_y),
        .left_btn       (left_btn),
        .color_out      (color_out),
        .roi_x0         (roi_x0),
        .roi_y0         (roi_y0),
        .roi_x1         (roi_x1),
        .roi_y1         (roi_y1),
        .roi_valid      (roi_valid),
        .roi_busy       (roi_busy)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Framebuffer with one pixel-tick read latency; contents are addr[7:0]
    always @(posedge clk_50MHz or negedge vga_reset) begin
        if (!vga_reset) ram_addr_q <= 19'd0;
        else if (pix_en) ram_addr_q <= fb_rdaddr;
    end
    assign fb_q = ram_addr_q[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic model_reset();
        m_w = 640; m_h = 480; m_xo = 0; m_yo = 0;
        m_roi_on = 1'b0;
        exp_q.delete();
    endtask

    function automatic int clampm(input int v, input int off, input int len);
        if (v < off) return 0;
        if (v - off > len - 1) return len - 1;
        return v - off;
    endfunction

    function automatic bit interesting(input int x, input int y);
        bit r;
        int cx, cy;
        cx = int'(cursor_x);
        cy = int'(cursor_y);
        r = (x == 0) || (x == 639) || (x == m_xo - 1) || (x == m_xo) || (x == m_xo + 1) ||
            (x == m_xo + m_w - 1) || (x == m_xo + m_w) || ($urandom_range(0, 199) == 0);
        if (y >= cy - 1 && y <= cy + 5 && x >= cx - 1 && x <= cx + 5) r = 1'b1;
        if (m_roi_on && y >= m_yo + m_ry0 - 1 && y <= m_yo + m_ry1 + 1) begin
            if (x >= m_xo + m_rx0 - 1 && x <= m_xo + m_rx0 + 1) r = 1'b1;
            if (x >= m_xo + m_rx1 - 1 && x <= m_xo + m_rx1 + 1) r = 1'b1;
            if ((y == m_yo + m_ry0 || y == m_yo + m_ry1) && x >= m_xo + m_rx0 && x <= m_xo + m_rx1)
                r = 1'b1;
        end
        return r;
    endfunction

    task automatic strobe(input int x, input int y);
        bit inimg, ch, rh;
        int lx, ly, ea, ec, cx, cy;
        if (x == 0 && y == 0) begin
            m_w  = int'(img_w);
            m_h  = int'(img_h);
            m_xo = (640 - m_w) / 2;
            m_yo = (480 - m_h) / 2;
        end
        cx = int'(cursor_x);
        cy = int'(cursor_y);
        inimg = x >= m_xo && x < m_xo + m_w && y >= m_yo && y < m_yo + m_h;
        lx = x - m_xo;
        ly = y - m_yo;
        ea = (inimg && display_enable) ? ly * m_w + lx : 0;
        ch = x >= cx && x < cx + 5 && y >= cy && y < cy + 5;
        rh = m_roi_on && inimg &&
             (((lx == m_rx0 || lx == m_rx1) && ly >= m_ry0 && ly <= m_ry1) ||
              ((ly == m_ry0 || ly == m_ry1) && lx >= m_rx0 && lx <= m_rx1));
        ec = ch ? 255 : rh ? 224 : (inimg && display_enable) ? (ea % 256) : 0;
        next_x = 10'(x);
        next_y = 10'(y);
        pix_en = 1'b1;
        @(posedge clk_50MHz);
        #1;
        pix_en = 1'b0;
        check("fb_rdaddr", 32'(fb_rdaddr), 32'(ea));
        exp_q.push_back(ec);
        if (exp_q.size() > LAG) check("color_out", 32'(color_out), 32'(exp_q.pop_front()));
        wait_cycles($urandom_range(0, 1));
    endtask

    task automatic run_frame(input int change_row);
        for (int y = 0; y < 480; y++) begin
            if (y == change_row) begin
                img_w = 10'd640;
                img_h = 10'd480;
            end
            for (int x = 0; x < 640; x++)
                if (interesting(x, y)) strobe(x, y);
        end
    endtask

    task automatic drag(input int px, input int py, input int qx, input int qy);
        int ax, ay, bx, by;
        ax = clampm(px, m_xo, m_w);
        ay = clampm(py, m_yo, m_h);
        bx = clampm(qx, m_xo, m_w);
        by = clampm(qy, m_yo, m_h);
        cursor_x = 10'(px);
        cursor_y = 10'(py);
        wait_cycles(2);
        left_btn = 1'b1;
        wait_cycles(6);
        check("busy_on_press", 32'(roi_busy), 32'd1);
        check("valid_on_press", 32'(roi_valid), 32'd0);
        cursor_x = 10'(qx);
        cursor_y = 10'(qy);
        wait_cycles(4);
        check("drag_x1", 32'(roi_x1), 32'((ax > bx) ? ax : bx));
        check("drag_y1", 32'(roi_y1), 32'((ay > by) ? ay : by));
        left_btn = 1'b0;
        wait_cycles(6);
        m_rx0 = (ax < bx) ? ax : bx;
        m_rx1 = (ax > bx) ? ax : bx;
        m_ry0 = (ay < by) ? ay : by;
        m_ry1 = (ay > by) ? ay : by;
        m_roi_on = 1'b1;
        check("roi_x0", 32'(roi_x0), 32'(m_rx0));
        check("roi_y0", 32'(roi_y0), 32'(m_ry0));
        check("roi_x1", 32'(roi_x1), 32'(m_rx1));
        check("roi_y1", 32'(roi_y1), 32'(m_ry1));
        check("roi_valid", 32'(roi_valid), 32'd1);
        check("roi_busy", 32'(roi_busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, 32'(fb_rdaddr), 32'd0);
        check({tag, "_color"}, 32'(color_out), 32'd0);
        check({tag, "_x0"}, 32'(roi_x0), 32'd0);
        check({tag, "_y0"}, 32'(roi_y0), 32'd0);
        check({tag, "_x1"}, 32'(roi_x1), 32'd0);
        check({tag, "_y1"}, 32'(roi_y1), 32'd0);
        check({tag, "_valid"}, 32'(roi_valid), 32'd0);
        check({tag, "_busy"}, 32'(roi_busy), 32'd0);
    endtask

    initial begin
        vga_reset = 1'b0;
        pix_en = 1'b0;
        next_x = 10'd0;
        next_y = 10'd0;
        img_w = 10'd320;
        img_h = 10'd240;
        display_enable = 1'b1;
        cursor_x = 10'd0;
        cursor_y = 10'd0;
        left_btn = 1'b0;
        model_reset();
        #25;
        check_reset_state("reset");
        @(posedge clk_50MHz);
        #1;
        vga_reset = 1'b1;
        wait_cycles(2);

        // Centred 320x240 image with a cursor somewhere inside it
        cursor_x = 10'($urandom_range(170, 460));
        cursor_y = 10'($urandom_range(130, 350));
        run_frame(-1);

        // Random drags (including clamped ones), a single-pixel ROI, then the reference drag
        for (int i = 0; i < 3; i++)
            drag($urandom_range(0, 639), $urandom_range(0, 479),
                 $urandom_range(0, 639), $urandom_range(0, 479));
        begin
            int sx, sy;
            sx = $urandom_range(160, 479);
            sy = $urandom_range(120, 359);
            drag(sx, sy, sx, sy);
            check("one_pixel_w", 32'(roi_x1 - roi_x0), 32'd0);
        end
        drag(200, 150, 170, 300);

        // Outline visible; geometry request changes mid-frame but applies next frame
        cursor_x = 10'($urandom_range(0, 635));
        cursor_y = 10'($urandom_range(0, 475));
        run_frame(200);
        cursor_x = 10'd0;
        cursor_y = 10'd0;
        run_frame(-1);

        // Reset in the middle of a drag
        cursor_x = 10'd300;
        cursor_y = 10'd200;
        wait_cycles(2);
        left_btn = 1'b1;
        wait_cycles(6);
        check("busy_before_reset", 32'(roi_busy), 32'd1);
        #3;
        vga_reset = 1'b0;
        #1;
        check_reset_state("mid_drag_reset");
        left_btn = 1'b0;
        wait_cycles(4);
        vga_reset = 1'b1;
        model_reset();
        wait_cycles(4);

        // Display disabled: only the edge-clipped cursor is drawn
        display_enable = 1'b0;
        cursor_x = 10'd638;
        cursor_y = 10'd478;
        run_frame(-1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
